hc_sr04_ping_scheduler: RTL and testbench

Round-robin ping scheduler that time-multiplexes up to N HC-SR04 ultrasound sensors, so only one sensor is ever in flight and echoes cannot crosstalk. For the selected sensor it drives the trigger pulse, waits for the echo rising edge, measures the echo high width in clock ticks, applies a timeout guard, and then inserts a hold-off gap before moving to the next enabled sensor. Each measurement is reported as a single-cycle result tagged with the sensor id. It sits between the sensor pins and the distance-processing logic.

---
 rtl/hc_sr04_ping_scheduler.sv | 157 +++++++++++++++
 tb/tb_hc_sr04_ping_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hc_sr04_ping_scheduler.sv
// hc_sr04_ping_scheduler: round-robin trigger/echo timing for up to 16 HC-SR04 sensors, one in flight at a time
module hc_sr04_ping_scheduler #(
   parameter int CLK_FREQ         = 100000000,
   parameter int N_SENSORS        = 4,
   parameter int TRIG_DURATION_US = 10,
   parameter int ECHO_TIMEOUT_US  = 30000,
   parameter int HOLDOFF_US       = 10000,
   parameter int O_WL             = 32,
   localparam int IW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic [N_SENSORS-1:0] sensor_mask,
   output logic [N_SENSORS-1:0] sn_trigger,
   input  logic [N_SENSORS-1:0] sn_echo,
   output logic                 busy,
   output logic                 o_valid,
   output logic [IW-1:0]        o_sensor_id,
   output logic [O_WL-1:0]      o_ticks,
   output logic                 o_timeout
);
   localparam longint TRIG_CNT = longint'(TRIG_DURATION_US) * longint'(CLK_FREQ) / 64'sd1000000;
   localparam longint TO_CNT   = longint'(ECHO_TIMEOUT_US) * longint'(CLK_FREQ) / 64'sd1000000;
   localparam longint HOLD_CNT = longint'(HOLDOFF_US) * longint'(CLK_FREQ) / 64'sd1000000;
   localparam longint MAX_AB   = (TRIG_CNT > TO_CNT) ? TRIG_CNT : TO_CNT;
   localparam longint MAXC     = (MAX_AB > HOLD_CNT) ? MAX_AB : HOLD_CNT;
   localparam int     CW       = $clog2(MAXC + 1);

   if (TO_CNT > longint'((64'd1 << O_WL) - 64'd1)) begin : g_bad_width
      $error("o_ticks width O_WL cannot hold the echo timeout count");
   end
   if (N_SENSORS < 1 || N_SENSORS > 16) begin : g_bad_count
      $error("N_SENSORS must be in 1..16");
   end

   typedef enum logic [2:0] {IDLE, SELECT, TRIG, WAIT_RISE, MEASURE, REPORT, HOLDOFF} state_t;

   state_t               state, nxt;
   logic [N_SENSORS-1:0] echo_s1, echo_s2, echo_d, rise_q, fall_q;
   logic [IW-1:0]        id, id_n, pick, cand;
   logic                 found;
   logic [CW-1:0]        cnt, cnt_n;
   logic [O_WL-1:0]      res_ticks;
   logic                 res_to;

   // two-flop synchronizer plus registered edge flags, so rise and fall see identical delay
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         echo_s1 <= '0;
         echo_s2 <= '0;
         echo_d  <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
      end else begin
         echo_s1 <= sn_echo;
         echo_s2 <= echo_s1;
         echo_d  <= echo_s2;
         rise_q  <= echo_s2 & ~echo_d;
         fall_q  <= ~echo_s2 & echo_d;
      end
   end

   // first enabled sensor strictly after the last served id, wrapping around
   always_comb begin
      pick  = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= N_SENSORS; k++) begin
         cand = IW'((int'(id) + k) % N_SENSORS);
         if (!found && sensor_mask[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // next-state, counter and result selection
   always_comb begin
      nxt       = state;
      id_n      = id;
      cnt_n     = cnt;
      res_ticks = '0;
      res_to    = 1'b0;
      case (state)
         IDLE:      nxt = (enable && |sensor_mask) ? SELECT : IDLE;
         SELECT: begin
            cnt_n = '0;
            id_n  = found ? pick : id;
            nxt   = found ? TRIG : IDLE;
         end
         TRIG: begin
            nxt   = (cnt == CW'(TRIG_CNT - 1)) ? WAIT_RISE : TRIG;
            cnt_n = (cnt == CW'(TRIG_CNT - 1)) ? '0 : cnt + CW'(1);
         end
         WAIT_RISE: begin
            if (rise_q[id]) begin
               cnt_n = CW'(1);
               nxt   = MEASURE;
            end else if (cnt == CW'(TO_CNT)) begin
               res_to = 1'b1;
               nxt    = REPORT;
            end else
               cnt_n = cnt + CW'(1);
         end
         MEASURE: begin
            res_ticks = O_WL'(cnt);
            if (fall_q[id])
               nxt = REPORT;
            else if (cnt == CW'(TO_CNT)) begin
               res_to = 1'b1;
               nxt    = REPORT;
            end else
               cnt_n = cnt + CW'(1);
         end
         REPORT: begin
            cnt_n = '0;
            nxt   = HOLDOFF;
         end
         HOLDOFF: begin
            if (cnt == CW'(HOLD_CNT - 1)) begin
               cnt_n = '0;
               nxt   = (enable && |sensor_mask) ? SELECT : IDLE;
            end else
               cnt_n = cnt + CW'(1);
         end
         default:   nxt = IDLE;
      endcase
   end

   // state register and registered pin/result outputs; id resets to the last slot so sensor 0 is searched first
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         id          <= IW'(N_SENSORS - 1);
         cnt         <= '0;
         sn_trigger  <= '0;
         busy        <= 1'b0;
         o_valid     <= 1'b0;
         o_sensor_id <= '0;
         o_ticks     <= '0;
         o_timeout   <= 1'b0;
      end else begin
         state      <= nxt;
         id         <= id_n;
         cnt        <= cnt_n;
         sn_trigger <= (nxt == TRIG) ? (N_SENSORS'(1) << id_n) : '0;
         busy       <= (nxt != IDLE);
         o_valid    <= (nxt == REPORT);
         if (nxt == REPORT) begin
            o_sensor_id <= id;
            o_ticks     <= res_ticks;
            o_timeout   <= res_to;
         end
      end
   end
endmodule

// File: tb/tb_hc_sr04_ping_scheduler.sv
// tb_hc_sr04_ping_scheduler: directed pings with a result scoreboard checked by an independent monitor
module tb_hc_sr04_ping_scheduler;
   logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0, n1 = 1'b0, noise_en = 1'b0;
   logic [3:0]  sensor_mask = '0, echo = '0;
   logic [3:0]  sn_trigger;
   logic        busy, o_valid, o_timeout;
   logic [1:0]  o_sensor_id;
   logic [31:0] o_ticks;
   int          checks = 0, errors = 0, cyc = 0, valid_cyc = 0, trig_cyc = 0, fall_cyc = 0;

   typedef struct {int id; int ticks; bit to;} exp_t;
   exp_t q[$];

   hc_sr04_ping_scheduler #(
      .CLK_FREQ(1000000), .N_SENSORS(4), .TRIG_DURATION_US(10),
      .ECHO_TIMEOUT_US(1000), .HOLDOFF_US(100), .O_WL(32)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .sensor_mask(sensor_mask),
      .sn_trigger(sn_trigger), .sn_echo(echo | {2'b00, n1, 1'b0}), .busy(busy),
      .o_valid(o_valid), .o_sensor_id(o_sensor_id), .o_ticks(o_ticks), .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) n1 = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   always @(negedge clk) begin
      if (o_valid) begin
         valid_cyc = cyc;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got id %0d ticks %0d timeout %0d, expected none", o_sensor_id, o_ticks, o_timeout);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("res_id", o_sensor_id, e.id);
            chk("res_ticks", o_ticks, e.ticks);
            chk("res_timeout", o_timeout, e.to);
         end
      end
   end

   task automatic wait_trig(input int id, output bit ok);
      int n = 0;
      logic [3:0] want;
      want = 4'(1 << id);
      ok = 1'b0;
      @(negedge clk);
      while (sn_trigger == 4'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (sn_trigger == 4'b0) begin
         checks++;
         errors++;
         $display("FAIL trig_wait: got no trigger expected sensor %0d", id);
         return;
      end
      ok = 1'b1;
      trig_cyc = cyc;
      chk("trig_sel", sn_trigger, want);
      n = 0;
      while (sn_trigger != 4'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("trig_len", n, 10);
      fall_cyc = cyc;
   endtask

   task automatic wait_q();
      int n = 0;
      while (q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL report_wait: got no o_valid expected %0d pending results", q.size());
         q.delete();
      end
   endtask

   task automatic ping(input int id, input int rise, input int width, input int ticks, input bit to);
      bit ok;
      wait_trig(id, ok);
      if (!ok) return;
      q.push_back('{id, ticks, to});
      if (rise >= 0) begin
         repeat (rise) @(negedge clk);
         echo[id] = 1'b1;
         if (width > 0) begin
            repeat (width) @(negedge clk);
            echo[id] = 1'b0;
         end
      end
      wait_q();
   endtask

   initial begin
      int v, viol;
      bit ok;
      repeat (3) @(negedge clk);
      chk("rst_trigger", sn_trigger, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_ticks", o_ticks, 0);
      chk("rst_id", o_sensor_id, 0);
      chk("rst_timeout", o_timeout, 0);
      reset_n = 1'b1;
      sensor_mask = 4'b0101;
      enable = 1'b1;
      ping(0, 50, 500, 500, 0);
      v = valid_cyc;
      ping(2, 20, 300, 300, 0);
      chk("holdoff_gap", trig_cyc - v, 102);
      ping(0, -1, 0, 0, 1);
      chk_rng("timeout_latency", valid_cyc - fall_cyc, 1000, 1002);
      echo[2] = 1'b1;
      ping(2, -1, 0, 0, 1);
      echo[2] = 1'b0;
      ping(0, 30, -1, 1000, 1);
      echo[0] = 1'b0;
      sensor_mask = 4'b0000;
      repeat (150) @(negedge clk);
      viol = 0;
      repeat (5000) begin
         @(negedge clk);
         if (busy || sn_trigger != 4'b0) viol++;
      end
      chk("idle_quiet", viol, 0);
      sensor_mask = 4'b1000;
      noise_en = 1'b1;
      ping(3, 10, 77, 77, 0);
      ping(3, 5, 200, 200, 0);
      ping(3, 40, 1, 1, 0);
      noise_en = 1'b0;
      sensor_mask = 4'b0101;
      wait_trig(0, ok);
      repeat (10) @(negedge clk);
      echo[0] = 1'b1;
      repeat (100) @(negedge clk);
      chk("busy_measure", busy, 1);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("arst_trigger", sn_trigger, 0);
      chk("arst_valid", o_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_ticks", o_ticks, 0);
      chk("arst_id", o_sensor_id, 0);
      echo = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      ping(0, 20, 150, 150, 0);
      wait_trig(2, ok);
      if (ok) begin
         q.push_back('{2, 250, 1'b0});
         repeat (15) @(negedge clk);
         echo[2] = 1'b1;
         repeat (100) @(negedge clk);
         enable = 1'b0;
         repeat (150) @(negedge clk);
         echo[2] = 1'b0;
         wait_q();
      end
      repeat (105) @(negedge clk);
      chk("idle_after_drop", busy, 0);
      viol = 0;
      repeat (500) begin
         @(negedge clk);
         if (busy || sn_trigger != 4'b0) viol++;
      end
      chk("no_retrigger", viol, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
